// File: rtl/spi_xfer_ctrl.sv
// SPI host transfer sequencer: one request in, CS/clock-generator control out, mode 0 shifting.
// Optional abort support is compiled in with `define SPI_XFER_ABORT_EN.
module spi_xfer_ctrl #(
    parameter int DATA_W    = 32,
    parameter int CNT_W     = 6,
    parameter int SETUP_CYC = 2,
    parameter int HOLD_CYC  = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [DATA_W-1:0] req_data_i,
    input  logic [CNT_W-1:0]  req_len_i,
    input  logic              req_lsb_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              busy_o,
    output logic              cs_no,
    output logic              sdo_o,
    input  logic              sdi_i,
`ifdef SPI_XFER_ABORT_EN
    input  logic              abort_i,
    output logic              rsp_abort_o,
`endif
    output logic              clg_enable_o,
    output logic              clg_go_o,
    output logic              clg_last_clk_o,
    input  logic              clg_pos_edge_i,
    input  logic              clg_neg_edge_i
);

    localparam int CYC_MAX = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_XFER  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t            state_r;
    logic [DATA_W-1:0] tx_r;
    logic [DATA_W-1:0] rx_r;
    logic [CNT_W-1:0]  shamt_r;
    logic              lsb_r;
    logic [CNT_W-1:0]  bits_left_r;
    logic [CYC_W-1:0]  cyc_cnt_r;
    logic              aborted_r;
    logic              cs_n_r;
    logic              sdo_r;
    logic              en_r;
    logic              go_r;
    logic              last_r;
    logic              rsp_valid_r;
    logic [DATA_W-1:0] rsp_data_r;
`ifdef SPI_XFER_ABORT_EN
    logic              rsp_abort_r;
`endif

    logic [CNT_W-1:0]  eff_len_s;
    logic [CNT_W-1:0]  shamt_s;
    logic [DATA_W-1:0] tx_align_s;
    logic [DATA_W-1:0] tx_next_s;
    logic [DATA_W-1:0] rx_next_s;
    logic [DATA_W-1:0] rx_align_s;
    logic [CNT_W-1:0]  bits_dec_s;
    logic              first_bit_s;
    logic              next_bit_s;
    logic              abort_s;

`ifdef SPI_XFER_ABORT_EN
    assign abort_s     = abort_i;
    assign rsp_abort_o = rsp_abort_r;
`else
    assign abort_s     = 1'b0;
`endif

    // Request alignment and per-edge shift/count datapath.
    always_comb begin
        eff_len_s = req_len_i;
        if (req_len_i == {CNT_W{1'b0}}) begin
            eff_len_s = CNT_W'(DATA_W);
        end else begin
            eff_len_s = req_len_i;
        end
        shamt_s = CNT_W'(DATA_W) - eff_len_s;
        // MSB-first data is pre-shifted so bit len-1 leaves from the top.
        if (req_lsb_i) begin
            tx_align_s  = req_data_i;
            first_bit_s = req_data_i[0];
        end else begin
            tx_align_s  = req_data_i << shamt_s;
            first_bit_s = tx_align_s[DATA_W-1];
        end
        if (lsb_r) begin
            tx_next_s  = {1'b0, tx_r[DATA_W-1:1]};
            next_bit_s = tx_next_s[0];
            rx_next_s  = {sdi_i, rx_r[DATA_W-1:1]};
        end else begin
            tx_next_s  = {tx_r[DATA_W-2:0], 1'b0};
            next_bit_s = tx_next_s[DATA_W-1];
            rx_next_s  = {rx_r[DATA_W-2:0], sdi_i};
        end
        if (clg_pos_edge_i && (bits_left_r != {CNT_W{1'b0}})) begin
            bits_dec_s = bits_left_r - CNT_W'(1);
        end else begin
            bits_dec_s = bits_left_r;
        end
        if (lsb_r && !aborted_r) begin
            rx_align_s = rx_r >> shamt_r;
        end else begin
            rx_align_s = rx_r;
        end
    end

    // Transfer FSM with all handshake and clock-generator outputs registered.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r     <= ST_IDLE;
            tx_r        <= {DATA_W{1'b0}};
            rx_r        <= {DATA_W{1'b0}};
            shamt_r     <= {CNT_W{1'b0}};
            lsb_r       <= 1'b0;
            bits_left_r <= {CNT_W{1'b0}};
            cyc_cnt_r   <= {CYC_W{1'b0}};
            aborted_r   <= 1'b0;
            cs_n_r      <= 1'b1;
            sdo_r       <= 1'b0;
            en_r        <= 1'b0;
            go_r        <= 1'b0;
            last_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= {DATA_W{1'b0}};
`ifdef SPI_XFER_ABORT_EN
            rsp_abort_r <= 1'b0;
`endif
        end else begin
            rsp_valid_r <= 1'b0;
            go_r        <= 1'b0;
`ifdef SPI_XFER_ABORT_EN
            rsp_abort_r <= 1'b0;
`endif
            case (state_r)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        state_r     <= ST_SETUP;
                        cs_n_r      <= 1'b0;
                        tx_r        <= tx_align_s;
                        sdo_r       <= first_bit_s;
                        rx_r        <= {DATA_W{1'b0}};
                        shamt_r     <= shamt_s;
                        lsb_r       <= req_lsb_i;
                        bits_left_r <= eff_len_s;
                        cyc_cnt_r   <= {CYC_W{1'b0}};
                        aborted_r   <= 1'b0;
                        go_r        <= (SETUP_CYC == 1);
                    end
                end
                ST_SETUP: begin
                    if (abort_s) begin
                        state_r   <= ST_HOLD;
                        cyc_cnt_r <= {CYC_W{1'b0}};
                        aborted_r <= 1'b1;
                    end else if (cyc_cnt_r == CYC_W'(SETUP_CYC - 1)) begin
                        state_r <= ST_XFER;
                        en_r    <= 1'b1;
                        last_r  <= 1'b0;
                    end else begin
                        cyc_cnt_r <= cyc_cnt_r + CYC_W'(1);
                        go_r      <= ((cyc_cnt_r + CYC_W'(1)) == CYC_W'(SETUP_CYC - 1));
                    end
                end
                ST_XFER: begin
                    if (abort_s) begin
                        state_r   <= ST_HOLD;
                        en_r      <= 1'b0;
                        last_r    <= 1'b0;
                        cyc_cnt_r <= {CYC_W{1'b0}};
                        aborted_r <= 1'b1;
                    end else begin
                        if (clg_pos_edge_i) begin
                            rx_r        <= rx_next_s;
                            bits_left_r <= bits_dec_s;
                        end
                        // neg_edge sees the count already updated by a coincident pos_edge.
                        if (clg_neg_edge_i && (bits_dec_s == {CNT_W{1'b0}})) begin
                            state_r   <= ST_HOLD;
                            en_r      <= 1'b0;
                            last_r    <= 1'b0;
                            cyc_cnt_r <= {CYC_W{1'b0}};
                        end else begin
                            last_r <= (bits_dec_s == {CNT_W{1'b0}});
                            if (clg_neg_edge_i) begin
                                tx_r  <= tx_next_s;
                                sdo_r <= next_bit_s;
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (cyc_cnt_r == CYC_W'(HOLD_CYC - 1)) begin
                        state_r     <= ST_IDLE;
                        cs_n_r      <= 1'b1;
                        rsp_valid_r <= 1'b1;
                        rsp_data_r  <= rx_align_s;
`ifdef SPI_XFER_ABORT_EN
                        rsp_abort_r <= aborted_r;
`endif
                    end else begin
                        cyc_cnt_r <= cyc_cnt_r + CYC_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o    = (state_r == ST_IDLE);
    assign busy_o         = (state_r != ST_IDLE);
    assign cs_no          = cs_n_r;
    assign sdo_o          = sdo_r;
    assign clg_enable_o   = en_r;
    assign clg_go_o       = go_r;
    assign clg_last_clk_o = last_r;
    assign rsp_valid_o    = rsp_valid_r;
    assign rsp_data_o     = rsp_data_r;

endmodule
